sseg_mux_n: RTL

Parametrised N-digit multiplexed seven-segment display driver with internal hex decode, per-digit decimal points, leading-zero blanking and 16-level PWM brightness. It is the next-generation replacement for the fixed 4-digit decoder-plus-mux arrangement and drives board anodes and segments directly. Display data is double-buffered and committed only at frame boundaries, so a digit update never tears mid-frame.

---
 rtl/sseg_mux_n.sv | 80 ++++++++
 1 files changed

// File: rtl/sseg_mux_n.sv
// sseg_mux_n: N-digit multiplexed seven-segment driver with hex decode, LZB and PWM.
// Display data is double-buffered; the shadow copy is committed only at frame boundaries.
module sseg_mux_n #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [16*7-1:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  logic [PRESCALE_BITS-1:0] presc_q, presc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]  pend_hex_q, pend_hex_d, shad_hex_q, shad_hex_d;
  logic [NUM_DIGITS-1:0]    pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic [NUM_DIGITS-1:0]    an_q, an_d;
  logic [7:0]               sseg_q, sseg_d;
  logic                     tick_q, tick_d;
  logic                     slot_end, frame_end, on;
  logic [3:0]               nib;
  logic [NUM_DIGITS-1:0]    lead;
  // lead[g]: digit g and everything to its left is a zero with no decimal point
  assign lead[0] = 1'b0;
  for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lead
    assign lead[g] = shad_hex_q[4*NUM_DIGITS-1:4*g] == '0 && shad_dp_q[NUM_DIGITS-1:g] == '0;
  end
  always_comb begin
    slot_end   = &presc_q;
    frame_end  = slot_end && idx_q == LAST;
    presc_d    = presc_q + 1'b1;
    idx_d      = slot_end ? (idx_q == LAST ? '0 : idx_q + 1'b1) : idx_q;
    pend_hex_d = load ? hex_in : pend_hex_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    shad_hex_d = frame_end ? pend_hex_d : shad_hex_q;
    shad_dp_d  = frame_end ? pend_dp_d : shad_dp_q;
    tick_d     = frame_end;
    nib        = shad_hex_q[4*idx_q +: 4];
    on         = presc_q[PRESCALE_BITS-1 -: 4] <= bright && !(lzb_en && lead[idx_q]);
    an_d       = on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    sseg_d     = on ? {~shad_dp_q[idx_q], SEG_LUT[7*nib +: 7]} : 8'hFF;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_hex_q <= '0;
      pend_dp_q  <= '0;
      shad_hex_q <= '0;
      shad_dp_q  <= '0;
      an_q       <= '1;
      sseg_q     <= 8'hFF;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_hex_q <= pend_hex_d;
      pend_dp_q  <= pend_dp_d;
      shad_hex_q <= shad_hex_d;
      shad_dp_q  <= shad_dp_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
      tick_q     <= tick_d;
    end
  end
  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;
endmodule
